// File: rtl/id_alloc_ctrl_pkg.sv
// rtl/id_alloc_ctrl_pkg.sv - shared types for the ID pool allocator
package id_alloc_ctrl_pkg;

  localparam int unsigned LOG_DEPTH_DEF = 6;

  typedef logic [LOG_DEPTH_DEF-1:0] id_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } alloc_state_t;

endpackage

// File: rtl/id_alloc_ctrl_rr_arbiter.sv
// rtl/id_alloc_ctrl_rr_arbiter.sv - round-robin arbiter, one-hot grant, pointer moves on grant
module rr_arbiter #(
  parameter int N     = 4,
  parameter int LOG_N = 2
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  logic [LOG_N-1:0] last_q, last_d;
  logic [LOG_N-1:0] idx;
  logic [LOG_N-1:0] gnt_idx;
  logic             found;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    gnt_o   = '0;
    gnt_idx = last_q;
    found   = 1'b0;
    idx     = '0;
    for (int i = 1; i <= N; i++) begin
      idx = LOG_N'((int'(last_q) + i) % N);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (found) begin
      last_d = gnt_idx;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      last_q <= LOG_N'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/id_alloc_ctrl.sv
// rtl/id_alloc_ctrl.sv - shared ID pool with round-robin allocate/free ports
// Pool is a circular queue filled at reset; a bitmap of handed-out IDs catches double frees.
module id_alloc_ctrl
  import id_alloc_ctrl_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int LOG_N     = 2,
  parameter int LOG_DEPTH = 6,
  parameter int RESERVE   = 2
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [N_REQ-1:0]           alloc_valid_i,
  output logic [N_REQ-1:0]           alloc_ready_o,
  output logic [LOG_DEPTH-1:0]       alloc_id_o,
  input  logic [N_REQ-1:0]           free_valid_i,
  input  logic [N_REQ*LOG_DEPTH-1:0] free_id_i,
  output logic [N_REQ-1:0]           free_ready_o,
  output logic [LOG_DEPTH:0]         free_count_o,
  output logic                       init_done_o,
  output logic                       err_double_free_o
);

  localparam int DEPTH = 2 ** LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] RESERVE_CNT = (LOG_DEPTH + 1)'(RESERVE);
  localparam logic [LOG_DEPTH:0] ONE         = {{LOG_DEPTH{1'b0}}, 1'b1};
  localparam logic [LOG_DEPTH:0] FULL_CNT    = {1'b1, {LOG_DEPTH{1'b0}}};

  alloc_state_t state_q, state_d;
  logic                 sync_q, sync_d;
  logic [LOG_DEPTH:0]   wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH:0]   rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH:0]   count_q, count_d;
  logic [DEPTH-1:0]     bitmap_q, bitmap_d;
  logic                 err_q, err_d;
  logic [LOG_DEPTH-1:0] mem_q [DEPTH];

  logic                 run;
  logic [LOG_DEPTH-1:0] head_id;
  logic [N_REQ-1:0]     elig;
  logic [N_REQ-1:0]     alloc_req, alloc_gnt;
  logic [N_REQ-1:0]     free_req, free_gnt;
  logic                 alloc_fire, free_fire;
  logic [LOG_DEPTH-1:0] free_sel_id;
  logic                 free_known, push, dbl_free, full;
  logic                 mem_we;
  logic [LOG_DEPTH-1:0] mem_waddr, mem_wdata;

  assign run     = (state_q == RUN);
  assign head_id = mem_q[rd_ptr_q[LOG_DEPTH-1:0]];
  assign full    = (wr_ptr_q[LOG_DEPTH] != rd_ptr_q[LOG_DEPTH]) &&
                   (wr_ptr_q[LOG_DEPTH-1:0] == rd_ptr_q[LOG_DEPTH-1:0]);

  // The last RESERVE entries are held back for requester 0.
  always_comb begin
    elig    = '0;
    elig[0] = (count_q != '0);
    for (int i = 1; i < N_REQ; i++) begin
      elig[i] = (count_q > RESERVE_CNT);
    end
  end

  assign alloc_req = alloc_valid_i & elig & {N_REQ{run}};
  assign free_req  = free_valid_i & {N_REQ{run}};

  rr_arbiter #(.N(N_REQ), .LOG_N(LOG_N)) u_alloc_arb (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .req_i  (alloc_req),
    .gnt_o  (alloc_gnt)
  );

  rr_arbiter #(.N(N_REQ), .LOG_N(LOG_N)) u_free_arb (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .req_i  (free_req),
    .gnt_o  (free_gnt)
  );

  assign alloc_fire = |alloc_gnt;
  assign free_fire  = |free_gnt;

  always_comb begin
    free_sel_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (free_gnt[i]) begin
        free_sel_id = free_id_i[i*LOG_DEPTH +: LOG_DEPTH];
      end
    end
  end

  // Bitmap is sampled before this cycle's grant, so freeing the ID being granted is an error.
  assign free_known = bitmap_q[free_sel_id];
  assign push       = free_fire & free_known;
  assign dbl_free   = free_fire & ~free_known;

  always_comb begin
    state_d   = state_q;
    sync_d    = sync_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    bitmap_d  = bitmap_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = wr_ptr_q[LOG_DEPTH-1:0];
    mem_wdata = free_sel_id;
    case (state_q)
      INIT: begin
        if (!sync_q) begin
          sync_d = 1'b1;
        end else begin
          mem_we    = 1'b1;
          mem_wdata = wr_ptr_q[LOG_DEPTH-1:0];
          wr_ptr_d  = wr_ptr_q + ONE;
          if (wr_ptr_q[LOG_DEPTH-1:0] == '1) begin
            state_d = RUN;
            count_d = FULL_CNT;
          end
        end
      end
      RUN: begin
        if (alloc_fire) begin
          rd_ptr_d          = rd_ptr_q + ONE;
          bitmap_d[head_id] = 1'b1;
        end
        if (push) begin
          mem_we                = 1'b1;
          wr_ptr_d              = wr_ptr_q + ONE;
          bitmap_d[free_sel_id] = 1'b0;
        end
        if (dbl_free) begin
          err_d = 1'b1;
        end
        if (push && !alloc_fire) begin
          count_d = count_q + ONE;
        end else if (!push && alloc_fire) begin
          count_d = count_q - ONE;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= INIT;
      sync_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      bitmap_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      bitmap_q <= bitmap_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rstn_i) !(push && full));

  assign alloc_ready_o     = alloc_gnt;
  assign free_ready_o      = free_gnt;
  assign alloc_id_o        = run ? head_id : '0;
  assign free_count_o      = count_q;
  assign init_done_o       = run;
  assign err_double_free_o = err_q;

endmodule
